// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

  // Error codes; only the single err flag reaches the port today.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous per-lane write, registered read. Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [31:0]           wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-wise write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with programmable wait states.
// Optional build macro: DMEM_BYTE_EN_EN (stores honour req_be lane enables).
//
// state     | meaning
// ST_IDLE   | req_ready high, waiting for a request
// ST_WAIT   | counting down inserted wait states
// ST_ACCESS | one cycle: error check, commit store or capture load data
// ST_RESP   | rsp_valid high until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;

  logic              err;
  logic [3:0]        lane_mask;
  logic [3:0]        arr_we;
  logic [IDX_W-1:0]  arr_raddr;
  logic [31:0]       arr_rdata;

  // The full word address (not just the index bits) is range checked, so no aliasing.
  assign err = (lat_addr[1:0] != 2'b00) ||
               (lat_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));

`ifdef DMEM_BYTE_EN_EN
  assign lane_mask = lat_be;
`else
  logic unused_be;
  assign unused_be = ^{req_be, lat_be};
  assign lane_mask = 4'hF;
`endif

  // A clocked reset in ACCESS must suppress the write, hence the reset term.
  assign arr_we = (state == ST_ACCESS && reset && lat_we && !err) ? lane_mask : 4'h0;

  // In IDLE the array pre-reads the incoming address so data is ready by ACCESS
  // even with zero wait states.
  assign arr_raddr = (state == ST_IDLE) ? req_addr[IDX_W+1:2] : lat_addr[IDX_W+1:2];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (lat_addr[IDX_W+1:2]),
    .wdata (lat_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            req_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ST_ACCESS: begin
          rsp_err   <= err;
          rsp_rdata <= (!err && !lat_we) ? arr_rdata : 32'd0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: instance a (WAIT_CYCLES=2) gets directed + random traffic,
// instance b (WAIT_CYCLES=0) gets a streaming back-to-back run.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WA    = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          acc;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we, rsp_ready, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        b_req_valid, b_req_we, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA), .ADDR_W(32)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) u_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_rsp_a = 0, n_rsp_b = 0, n_acc_b = 0, last_b = -1;
  req_t q_a[$], q_b[$];
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] last_rd_a, prev_rd;
  logic        last_er_a, prev_er, prev_v;
  bit          rnd_rdy = 0;
  logic        rdy_fixed = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endtask

  function automatic bit bad_addr(logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r;
    logic [3:0]  m;
`ifdef DMEM_BYTE_EN_EN
    m = be;
`else
    m = 4'hF | be;
`endif
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Monitor / scoreboard for instance a.
  always @(negedge clk) begin
    req_t r;
    logic [31:0] exp_rd;
    if (!reset) begin
      q_a.delete();
      prev_v = 1'b0;
    end else begin
      if (req_valid && req_ready) q_a.push_back('{req_we, req_addr, req_wdata, req_be, cyc});
      if (rsp_valid) begin
        check("a_req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (!prev_v) begin
          if (q_a.size() == 0) fail_now("a_unexpected_rsp");
          else check("a_latency", 32'(cyc - q_a[0].acc), 32'(WA + 2));
        end else begin
          check("a_rdata_stable", rsp_rdata, prev_rd);
          check("a_err_stable", {31'd0, rsp_err}, {31'd0, prev_er});
        end
        if (rsp_ready && q_a.size() != 0) begin
          r = q_a.pop_front();
          exp_rd = (bad_addr(r.addr) || r.we) ? 32'd0 : mem_a[r.addr[7:2]];
          check("a_rdata", rsp_rdata, exp_rd);
          check("a_err", {31'd0, rsp_err}, {31'd0, bad_addr(r.addr)});
          if (r.we && !bad_addr(r.addr)) mem_a[r.addr[7:2]] = merge(mem_a[r.addr[7:2]], r.wdata, r.be);
          last_rd_a = rsp_rdata;
          last_er_a = rsp_err;
          n_rsp_a++;
        end
      end
      prev_v  = rsp_valid && !rsp_ready;
      prev_rd = rsp_rdata;
      prev_er = rsp_err;
    end
  end

  // Monitor / scoreboard for instance b (streaming, rsp_ready tied high).
  always @(negedge clk) begin
    req_t r;
    logic [31:0] exp_rd;
    if (reset) begin
      if (b_req_valid && b_req_ready) begin
        q_b.push_back('{b_req_we, b_req_addr, b_req_wdata, b_req_be, cyc});
        n_acc_b++;
      end
      if (b_rsp_valid) begin
        if (q_b.size() == 0) fail_now("b_unexpected_rsp");
        else begin
          r = q_b.pop_front();
          check("b_latency", 32'(cyc - r.acc), 32'd2);
          if (last_b >= 0) check("b_spacing", 32'(cyc - last_b), 32'd3);
          last_b = cyc;
          exp_rd = (bad_addr(r.addr) || r.we) ? 32'd0 : mem_b[r.addr[7:2]];
          check("b_rdata", b_rsp_rdata, exp_rd);
          check("b_err", {31'd0, b_rsp_err}, {31'd0, bad_addr(r.addr)});
          if (r.we && !bad_addr(r.addr)) mem_b[r.addr[7:2]] = merge(mem_b[r.addr[7:2]], r.wdata, r.be);
          n_rsp_b++;
        end
      end
    end
  end

  // rsp_ready driver for instance a.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  task automatic issue(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    int t;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    t = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > 100) begin fail_now("a_accept_timeout"); break; end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(int target);
    int t;
    t = 0;
    while (n_rsp_a < target && t < 300) begin @(negedge clk); t++; end
    if (n_rsp_a < target) fail_now("a_rsp_timeout");
  endtask

  task automatic txn(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    int target;
    target = n_rsp_a + 1;
    issue(we, a, d, be);
    wait_rsp(target);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [31:0] a;
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    check("store_rdata_zero", last_rd_a, 32'd0);
    txn(1'b0, 32'h10, 32'd0, 4'hF);
    check("load_deadbeef", last_rd_a, 32'hDEADBEEF);

    txn(1'b0, 32'h13, 32'd0, 4'hF);
    check("misalign_err", {31'd0, last_er_a}, 32'd1);
    txn(1'b1, 32'h100, 32'h12345678, 4'hF);
    check("range_store_err", {31'd0, last_er_a}, 32'd1);
    txn(1'b0, 32'h100, 32'd0, 4'hF);
    check("range_load_err", {31'd0, last_er_a}, 32'd1);
    check("range_load_rdata", last_rd_a, 32'd0);
    txn(1'b0, 32'h0, 32'd0, 4'hF);
    check("no_alias_word0", {31'd0, (last_rd_a == 32'h12345678)}, 32'd0);

    txn(1'b1, 32'h8, 32'h0, 4'hF);
    txn(1'b1, 32'h8, 32'hCAFEBABE, 4'b0101);
    txn(1'b0, 32'h8, 32'd0, 4'hF);
`ifdef DMEM_BYTE_EN_EN
    check("be_merge", last_rd_a, 32'h00FE00BE);
`else
    check("be_merge", last_rd_a, 32'hCAFEBABE);
`endif
    txn(1'b1, 32'h8, 32'h55555555, 4'b0000);
    check("be_zero_err", {31'd0, last_er_a}, 32'd0);

    // Stall in RESP with ignored request pulses.
    rdy_fixed = 1'b0;
    @(posedge clk);
    issue(1'b0, 32'h10, 32'd0, 4'hF);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    if (!rsp_valid) fail_now("hold_rsp_timeout");
    repeat (5) begin
      @(posedge clk);
      #1;
      req_valid = ~req_valid; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'd0;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("hold_queue", 32'(q_a.size()), 32'd1);
    t = n_rsp_a + 1;
    rdy_fixed = 1'b1;
    wait_rsp(t);
    check("hold_load", last_rd_a, 32'hDEADBEEF);

    // Reset during WAIT of a store.
    txn(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF);
    issue(1'b1, 32'h20, 32'h11111111, 4'hF);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mrst_rsp_rdata", rsp_rdata, 32'd0);
    check("mrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    txn(1'b0, 32'h20, 32'd0, 4'hF);
    check("mrst_no_write", last_rd_a, 32'hAAAAAAAA);

    // Randomized traffic with random response back-pressure.
    rnd_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        1:       a = 32'h100 + 32'($urandom_range(0, 255) * 4);
        2:       a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3) * 4);
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    rnd_rdy = 0;

    // Back-to-back streaming on the zero-wait instance.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      b_req_valid = 1'b1;
      b_req_we    = (i < 10) || (i % 7 == 3);
      b_req_addr  = (i == 15) ? 32'h0000_0006 : (i == 20) ? 32'h0000_0100 : 32'((i % 10) * 4);
      b_req_wdata = $urandom;
      b_req_be    = 4'hF;
      t = 0;
      forever begin
        @(negedge clk);
        if (b_req_ready) break;
        t++;
        if (t > 20) begin fail_now("b_accept_timeout"); break; end
      end
    end
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    t = 0;
    while (n_rsp_b < 30 && t < 50) begin @(negedge clk); t++; end
    check("b_accept_count", 32'(n_acc_b), 32'd30);
    check("b_rsp_count", 32'(n_rsp_b), 32'd30);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
